// File: rtl/pc_gen_unit.sv
// Front-end PC generator: trap/mispredict redirect, prediction and sequential
// fetch-block stepping, with a valid/ready handshake and post-redirect bubbles.
module pc_gen_unit #(
    parameter int unsigned       XLEN             = 32,
    parameter logic [XLEN-1:0]   BOOT_PC          = 32'h0000_1000,
    parameter int unsigned       FETCH_WIDTH      = 1,
    parameter int unsigned       REDIRECT_BUBBLES = 0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic            res_valid_i,
    input  logic            res_mispredict_i,
    input  logic            res_taken_i,
    input  logic [XLEN-1:0] res_target_i,
    input  logic [XLEN-1:0] res_pc_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_target_i,
    input  logic            fetch_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            flush_o
);

    localparam logic [XLEN-1:0] FB         = XLEN'(FETCH_WIDTH * 4);
    localparam logic [XLEN-1:0] BLOCK_MASK = ~(FB - XLEN'(1));
    localparam logic [XLEN-1:0] WORD_MASK  = ~XLEN'(3);
    localparam logic [3:0]      BUBBLES    = 4'(REDIRECT_BUBBLES);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        BUBBLE
    } state_t;

    state_t          state;
    logic [3:0]      count;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            accept;
    logic [XLEN-1:0] next_seq_pc;

    always_comb begin
        redirect        = 1'b0;
        redirect_target = '0;
        if (trap_valid_i) begin
            redirect        = 1'b1;
            redirect_target = trap_target_i & WORD_MASK;
        end else if (res_valid_i && res_mispredict_i) begin
            redirect        = 1'b1;
            redirect_target = res_taken_i ? (res_target_i & WORD_MASK)
                                          : (res_pc_i + XLEN'(4));
        end
    end

    assign accept      = pc_valid_o && fetch_ready_i;
    assign next_seq_pc = (pc_o & BLOCK_MASK) + FB;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= BOOT;
            pc_o       <= BOOT_PC;
            pc_valid_o <= 1'b0;
            flush_o    <= 1'b0;
            count      <= '0;
        end else begin
            flush_o <= redirect;
            // A redirect overrides any accept or bubble progress in every state.
            if (redirect) begin
                pc_o <= redirect_target;
                if (BUBBLES == 4'd0) begin
                    state      <= RUN;
                    pc_valid_o <= 1'b1;
                    count      <= '0;
                end else begin
                    state      <= BUBBLE;
                    pc_valid_o <= 1'b0;
                    count      <= BUBBLES;
                end
            end else begin
                case (state)
                    BOOT: begin
                        state      <= RUN;
                        pc_valid_o <= 1'b1;
                    end
                    RUN: begin
                        pc_valid_o <= 1'b1;
                        if (accept) begin
                            pc_o <= pred_taken_i ? (pred_target_i & WORD_MASK)
                                                 : next_seq_pc;
                        end
                    end
                    BUBBLE: begin
                        if (count == 4'd1) begin
                            state      <= RUN;
                            pc_valid_o <= 1'b1;
                            count      <= '0;
                        end else begin
                            pc_valid_o <= 1'b0;
                            count      <= count - 4'd1;
                        end
                    end
                    default: begin
                        state      <= BOOT;
                        pc_valid_o <= 1'b0;
                        count      <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: a cycle-by-cycle vector trace on a 2-bubble,
// 8-byte-block instance plus reset and zero-bubble sequences.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_target = '0;
    logic        res_valid = 1'b0;
    logic        res_mispredict = 1'b0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic [31:0] res_pc = '0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_target = '0;
    logic        fetch_ready = 1'b0;

    logic [31:0] pc_m, pc_z;
    logic        valid_m, valid_z, flush_m, flush_z;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    pc_gen_unit #(
        .XLEN(32), .BOOT_PC(32'h0000_1000), .FETCH_WIDTH(2), .REDIRECT_BUBBLES(2)
    ) dut_main (
        .clk_i(clk), .rst_n_i(rst_n),
        .trap_valid_i(trap_valid), .trap_target_i(trap_target),
        .res_valid_i(res_valid), .res_mispredict_i(res_mispredict),
        .res_taken_i(res_taken), .res_target_i(res_target), .res_pc_i(res_pc),
        .pred_taken_i(pred_taken), .pred_target_i(pred_target),
        .fetch_ready_i(fetch_ready),
        .pc_o(pc_m), .pc_valid_o(valid_m), .flush_o(flush_m)
    );

    pc_gen_unit #(
        .XLEN(32), .BOOT_PC(32'h0000_1000), .FETCH_WIDTH(1), .REDIRECT_BUBBLES(0)
    ) dut_zero (
        .clk_i(clk), .rst_n_i(rst_n),
        .trap_valid_i(trap_valid), .trap_target_i(trap_target),
        .res_valid_i(res_valid), .res_mispredict_i(res_mispredict),
        .res_taken_i(res_taken), .res_target_i(res_target), .res_pc_i(res_pc),
        .pred_taken_i(pred_taken), .pred_target_i(pred_target),
        .fetch_ready_i(fetch_ready),
        .pc_o(pc_z), .pc_valid_o(valid_z), .flush_o(flush_z)
    );

    typedef struct {
        logic        trap_v;
        logic [31:0] trap_t;
        logic        res_v;
        logic        mis;
        logic        taken;
        logic [31:0] res_t;
        logic [31:0] rpc;
        logic        ptk;
        logic [31:0] pt;
        logic        rdy;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_flush;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs[NV];

    function automatic vec_t mk(logic tv, logic [31:0] tt, logic rv, logic mi, logic tk,
                                logic [31:0] rt, logic [31:0] rp, logic pk, logic [31:0] pt,
                                logic rd, logic [31:0] epc, logic ev, logic ef);
        vec_t v;
        v.trap_v = tv; v.trap_t = tt; v.res_v = rv; v.mis = mi; v.taken = tk;
        v.res_t = rt; v.rpc = rp; v.ptk = pk; v.pt = pt; v.rdy = rd;
        v.e_pc = epc; v.e_valid = ev; v.e_flush = ef;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] apc, input logic av,
                             input logic af, input logic [31:0] epc, input logic ev,
                             input logic ef);
        check32({tag, " pc"}, apc, epc);
        check32({tag, " valid"}, {31'd0, av}, {31'd0, ev});
        check32({tag, " flush"}, {31'd0, af}, {31'd0, ef});
    endtask

    task automatic idle_inputs(input logic rdy);
        trap_valid = 1'b0; trap_target = '0;
        res_valid = 1'b0; res_mispredict = 1'b0; res_taken = 1'b0;
        res_target = '0; res_pc = '0;
        pred_taken = 1'b0; pred_target = '0;
        fetch_ready = rdy;
    endtask

    initial begin
        //         trap  ttgt          rv mis tk rtgt          rpc           pk ptgt          rdy  exp pc        v  f
        vecs[0]  = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_1000, 1, 0);
        vecs[1]  = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_1008, 1, 0);
        vecs[2]  = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0000_1008, 1, 0);
        vecs[3]  = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0000_1008, 1, 0);
        vecs[4]  = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0000_1008, 1, 0);
        vecs[5]  = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_1010, 1, 0);
        vecs[6]  = mk(0, 32'h0,         1, 1, 0, 32'h0,        32'h0000_1004, 0, 32'h0,       1, 32'h0000_1008, 0, 1);
        vecs[7]  = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_1008, 0, 0);
        vecs[8]  = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_1008, 1, 0);
        vecs[9]  = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        1, 32'h0000_2006, 1, 32'h0000_2004, 1, 0);
        vecs[10] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_2008, 1, 0);
        vecs[11] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_2010, 1, 0);
        vecs[12] = mk(0, 32'h0,         1, 1, 1, 32'h0000_3000, 32'h0,       0, 32'h0,        1, 32'h0000_3000, 0, 1);
        vecs[13] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_3000, 0, 0);
        vecs[14] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_3000, 1, 0);
        vecs[15] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        1, 32'h0000_5000, 0, 32'h0000_3000, 1, 0);
        vecs[16] = mk(1, 32'h0000_8000, 1, 1, 1, 32'h0000_4000, 32'h0,       1, 32'h0000_5000, 1, 32'h0000_8000, 0, 1);
        vecs[17] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_8000, 0, 0);
        vecs[18] = mk(0, 32'h0,         1, 1, 0, 32'h0,        32'h0000_9000, 0, 32'h0,       1, 32'h0000_9004, 0, 1);
        vecs[19] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_9004, 0, 0);
        vecs[20] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_9004, 1, 0);
        vecs[21] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_9008, 1, 0);
        vecs[22] = mk(1, 32'hFFFF_FFFB, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'hFFFF_FFF8, 0, 1);
        vecs[23] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'hFFFF_FFF8, 0, 0);
        vecs[24] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'hFFFF_FFF8, 1, 0);
        vecs[25] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_0000, 1, 0);
        vecs[26] = mk(0, 32'h0,         1, 0, 1, 32'h0000_7000, 32'h0,       0, 32'h0,        1, 32'h0000_0008, 1, 0);
        vecs[27] = mk(0, 32'h0,         1, 1, 1, 32'h0000_3006, 32'h0,       0, 32'h0,        1, 32'h0000_3004, 0, 1);
        vecs[28] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0000_3004, 0, 0);
        vecs[29] = mk(0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0000_3004, 1, 0);
        vecs[30] = mk(0, 32'h0,         1, 1, 0, 32'h0,        32'hFFFF_FFFC, 0, 32'h0,       1, 32'h0000_0000, 0, 1);

        idle_inputs(1'b1);
        #12;
        check_out("reset", pc_m, valid_m, flush_m, 32'h0000_1000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_out("boot", pc_m, valid_m, flush_m, 32'h0000_1000, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            trap_valid     = vecs[i].trap_v;
            trap_target    = vecs[i].trap_t;
            res_valid      = vecs[i].res_v;
            res_mispredict = vecs[i].mis;
            res_taken      = vecs[i].taken;
            res_target     = vecs[i].res_t;
            res_pc         = vecs[i].rpc;
            pred_taken     = vecs[i].ptk;
            pred_target    = vecs[i].pt;
            fetch_ready    = vecs[i].rdy;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), pc_m, valid_m, flush_m,
                      vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_flush);
        end

        // Asynchronous reset mid-bubble: outputs drop without waiting for an edge.
        idle_inputs(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", pc_m, valid_m, flush_m, 32'h0000_1000, 1'b0, 1'b0);
        check_out("async_rst_z", pc_z, valid_z, flush_z, 32'h0000_1000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst_hold", pc_m, valid_m, flush_m, 32'h0000_1000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("reboot", pc_m, valid_m, flush_m, 32'h0000_1000, 1'b1, 1'b0);
        check_out("reboot_z", pc_z, valid_z, flush_z, 32'h0000_1000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_out("seq_after_rst", pc_m, valid_m, flush_m, 32'h0000_1008, 1'b1, 1'b0);
        check_out("seq_z", pc_z, valid_z, flush_z, 32'h0000_1004, 1'b1, 1'b0);

        // Zero-bubble instance: redirect keeps valid high with a flush pulse.
        trap_valid  = 1'b1;
        trap_target = 32'h0000_4002;
        @(posedge clk);
        #1;
        check_out("trap_z", pc_z, valid_z, flush_z, 32'h0000_4000, 1'b1, 1'b1);
        check_out("trap_m", pc_m, valid_m, flush_m, 32'h0000_4000, 1'b0, 1'b1);
        idle_inputs(1'b1);
        @(posedge clk);
        #1;
        check_out("post_trap_z", pc_z, valid_z, flush_z, 32'h0000_4004, 1'b1, 1'b0);
        check_out("post_trap_m", pc_m, valid_m, flush_m, 32'h0000_4000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
